// File: rtl/soc1_game_clock_pkg.sv
// Shared constants and types for the elapsed-game-time counter.
// Register addresses, STATUS/CONTROL bit positions and the BCD digit type.
package soc1_game_clock_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_SECONDS  = 3'd2;
  localparam logic [2:0] ADDR_BCD      = 3'd3;
  localparam logic [2:0] ADDR_PRESCALE = 3'd4;
  localparam logic [2:0] ADDR_SUBTICK  = 3'd5;

  localparam int ST_RUNNING   = 0;
  localparam int ST_SEC_EVENT = 1;
  localparam int ST_SATURATED = 2;

  localparam int CTL_IRQ_EN = 0;
  localparam int CTL_START  = 1;
  localparam int CTL_STOP   = 2;
  localparam int CTL_CLEAR  = 3;

  typedef logic [3:0] bcd_digit_t;

  function automatic bcd_digit_t bcd_next(input bcd_digit_t d);
    return (d == 4'd9) ? 4'd0 : bcd_digit_t'(d + 4'd1);
  endfunction

endpackage

// File: rtl/soc1_bcd_counter3.sv
// Three cascaded BCD digit counters (000-999) with increment and clear.
// carry_out flags the 999 state, where one more increment would wrap.
module soc1_bcd_counter3
  import soc1_game_clock_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        clr,
  output logic [11:0] bcd,
  output logic        carry_out
);

  bcd_digit_t units;
  bcd_digit_t tens;
  bcd_digit_t hundreds;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      units    <= 4'd0;
      tens     <= 4'd0;
      hundreds <= 4'd0;
    end else if (inc) begin
      units <= bcd_next(units);
      if (units == 4'd9) begin
        tens <= bcd_next(tens);
        if (tens == 4'd9) hundreds <= bcd_next(hundreds);
      end
    end
  end

  assign bcd       = {hundreds, tens, units};
  assign carry_out = (hundreds == 4'd9) && (tens == 4'd9) && (units == 4'd9);

endmodule

// File: rtl/soc1_game_clock.sv
// Elapsed-game-time counter: prescales timer ticks to seconds, saturates at
// MAX_SECONDS, and exposes binary/BCD counts plus a per-second irq.
module soc1_game_clock
  import soc1_game_clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000,
  parameter int MAX_SECONDS   = 999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        chipselect,
  input  logic [2:0]  address,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  output logic [11:0] bcd_out
);

  // Slave port: a write takes effect on the edge where chipselect & ~write_n
  // is sampled; readdata always reflects the address sampled on the previous
  // edge (no wait states, no read strobe).
  logic        wr, ctl_wr, status_wr, prescale_wr;
  logic        start_req, stop_req, clear_req;
  logic        tick_ok, rollover, at_max, sat_hit, sec_inc;
  logic        running, sec_event, saturated, irq_en, bcd_carry;
  logic [15:0] prescale, subtick, ps_last;
  logic [9:0]  seconds;

  assign wr          = chipselect & ~write_n;
  assign ctl_wr      = wr && (address == ADDR_CONTROL);
  assign status_wr   = wr && (address == ADDR_STATUS);
  assign prescale_wr = wr && (address == ADDR_PRESCALE);
  assign start_req   = ctl_wr & writedata[CTL_START];
  assign stop_req    = ctl_wr & writedata[CTL_STOP];
  assign clear_req   = ctl_wr & writedata[CTL_CLEAR];

  // A prescale of 0 behaves as 1, so the last subtick is then 0 as well.
  assign ps_last  = (prescale == 16'd0) ? 16'd0 : prescale - 16'd1;
  // Clear, stop and a prescale write all swallow a coincident tick.
  assign tick_ok  = tick_in & running & ~stop_req & ~clear_req & ~prescale_wr;
  assign rollover = tick_ok && (subtick == ps_last);
  assign at_max   = (seconds == 10'(MAX_SECONDS)) || bcd_carry;
  assign sat_hit  = rollover & at_max;
  assign sec_inc  = rollover & ~at_max;

  always_ff @(posedge clk) begin
    if (reset) begin
      running   <= 1'b0;
      sec_event <= 1'b0;
      saturated <= 1'b0;
      irq_en    <= 1'b0;
      prescale  <= 16'(TICKS_PER_SEC);
      subtick   <= 16'd0;
      seconds   <= 10'd0;
    end else begin
      if (sat_hit || stop_req)            running <= 1'b0;
      else if (start_req && !saturated)   running <= 1'b1;

      if (sec_inc)        sec_event <= 1'b1;
      else if (status_wr) sec_event <= 1'b0;

      if (clear_req)      saturated <= 1'b0;
      else if (sat_hit)   saturated <= 1'b1;
      else if (status_wr) saturated <= 1'b0;

      if (ctl_wr)      irq_en   <= writedata[CTL_IRQ_EN];
      if (prescale_wr) prescale <= writedata;

      if (clear_req || prescale_wr || rollover) subtick <= 16'd0;
      else if (tick_ok)                         subtick <= subtick + 16'd1;

      if (clear_req)    seconds <= 10'd0;
      else if (sec_inc) seconds <= seconds + 10'd1;
    end
  end

  soc1_bcd_counter3 u_bcd (
    .clk       (clk),
    .reset     (reset),
    .inc       (sec_inc),
    .clr       (clear_req),
    .bcd       (bcd_out),
    .carry_out (bcd_carry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= 16'd0;
    end else begin
      case (address)
        ADDR_STATUS:   readdata <= {13'd0, saturated, sec_event, running};
        ADDR_CONTROL:  readdata <= {15'd0, irq_en};
        ADDR_SECONDS:  readdata <= {6'd0, seconds};
        ADDR_BCD:      readdata <= {4'd0, bcd_out};
        ADDR_PRESCALE: readdata <= prescale;
        ADDR_SUBTICK:  readdata <= subtick;
        default:       readdata <= 16'd0;
      endcase
    end
  end

  assign irq = sec_event & irq_en;

endmodule

// File: tb/tb_soc1_game_clock.sv
// Scoreboard bench for soc1_game_clock: directed scenarios plus random
// traffic, checked against an arithmetic reference model of the counter.
module tb_soc1_game_clock;

  localparam int TPS  = 1000;
  localparam int MAXS = 999;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick_in;
  logic        chipselect;
  logic [2:0]  address;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;
  logic [11:0] bcd_out;

  soc1_game_clock #(.TICKS_PER_SEC(TPS), .MAX_SECONDS(MAXS)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_in    (tick_in),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .bcd_out    (bcd_out)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [12:0] exp_out_q[$];
  logic        rd_valid = 1'b0;
  logic [15:0] rd_e;
  logic [12:0] out_e;

  // ---------------- reference model ----------------
  int m_running, m_sat, m_event, m_irq_en, m_prescale, m_sub, m_sec;

  function automatic int to_bcd(input int s);
    return ((s / 100) << 8) | (((s / 10) % 10) << 4) | (s % 10);
  endfunction

  function automatic logic [15:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return 16'((m_sat << 2) | (m_event << 1) | m_running);
      3'd1:    return 16'(m_irq_en);
      3'd2:    return 16'(m_sec);
      3'd3:    return 16'(to_bcd(m_sec));
      3'd4:    return 16'(m_prescale);
      3'd5:    return 16'(m_sub);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_step(input logic rst, input logic cs, input logic wn,
                            input logic [2:0] a, input logic [15:0] wd, input logic tk);
    bit wr_b, ctl, st_wr, pre_wr, start, stop, clr, counted, new_sec, hit_max;
    int ps, old_sat;
    if (rst) begin
      m_running = 0; m_sat = 0; m_event = 0; m_irq_en = 0;
      m_prescale = TPS; m_sub = 0; m_sec = 0;
      return;
    end
    wr_b    = cs && !wn;
    ctl     = wr_b && (a == 3'd1);
    st_wr   = wr_b && (a == 3'd0);
    pre_wr  = wr_b && (a == 3'd4);
    start   = ctl && wd[1];
    stop    = ctl && wd[2];
    clr     = ctl && wd[3];
    ps      = (m_prescale == 0) ? 1 : m_prescale;
    counted = tk && (m_running != 0) && !stop && !clr && !pre_wr;
    new_sec = 0;
    hit_max = 0;
    old_sat = m_sat;
    if (counted) begin
      if (m_sub + 1 >= ps) begin
        m_sub = 0;
        if (m_sec >= MAXS) hit_max = 1;
        else begin m_sec = m_sec + 1; new_sec = 1; end
      end else m_sub = m_sub + 1;
    end
    if (hit_max || stop)            m_running = 0;
    else if (start && old_sat == 0) m_running = 1;
    if (clr)          m_sat = 0;
    else if (hit_max) m_sat = 1;
    else if (st_wr)   m_sat = 0;
    if (new_sec)    m_event = 1;
    else if (st_wr) m_event = 0;
    if (clr)    begin m_sec = 0; m_sub = 0; end
    if (pre_wr) begin m_sub = 0; m_prescale = int'(wd); end
    if (ctl)    m_irq_en = int'(wd[0]);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic cs, input logic wn,
                       input logic [2:0] a, input logic [15:0] wd, input logic tk);
    logic        is_rd;
    logic [15:0] rexp;
    reset = rst; chipselect = cs; write_n = wn; address = a;
    writedata = wd; tick_in = tk;
    is_rd = rst || (cs && wn);
    rexp  = rst ? 16'h0000 : model_read(a);
    model_step(rst, cs, wn, a, wd, tk);
    @(posedge clk);
    if (is_rd) exp_q.push_back(rexp);
    exp_out_q.push_back({(m_event != 0 && m_irq_en != 0), 12'(to_bcd(m_sec))});
    #1;
  endtask

  task automatic do_wr(input logic [2:0] a, input logic [15:0] wd, input logic tk);
    drive(1'b0, 1'b1, 1'b0, a, wd, tk);
  endtask

  task automatic do_rd(input logic [2:0] a);
    drive(1'b0, 1'b1, 1'b1, a, 16'h0000, 1'b0);
  endtask

  task automatic ticks(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 1'b1);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) rd_valid <= reset || (chipselect && write_n);

  always @(negedge clk) begin
    if (exp_out_q.size() > 0) begin
      out_e = exp_out_q.pop_front();
      checks++;
      if ({irq, bcd_out} !== out_e) begin
        errors++;
        $display("FAIL outputs: got irq=%0b bcd=%03h, expected irq=%0b bcd=%03h at %0t",
                 irq, bcd_out, out_e[12], out_e[11:0], $time);
      end
    end
    if (rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected: readdata=%04h with no expectation at %0t", readdata, $time);
      end else begin
        rd_e = exp_q.pop_front();
        if (readdata !== rd_e) begin
          errors++;
          $display("FAIL readdata: got %04h, expected %04h at %0t", readdata, rd_e, $time);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic        cs, wn, tk;
    logic [2:0]  a;
    logic [15:0] wd;

    drive(1'b1, 1'b0, 1'b1, 3'd0, 16'h0000, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 3'd0, 16'h0000, 1'b0);
    for (int i = 0; i < 8; i++) do_rd(3'(i));

    // prescale 4, irq enabled, two seconds with a STATUS ack in between
    do_wr(3'd4, 16'd4, 1'b0);
    do_wr(3'd1, 16'h0001, 1'b0);
    do_wr(3'd1, 16'h0003, 1'b0);
    ticks(4);
    do_wr(3'd0, 16'h0000, 1'b0);
    ticks(4);
    do_rd(3'd2);
    do_rd(3'd3);
    do_rd(3'd0);

    // run to saturation at prescale 1, passing every BCD carry
    do_wr(3'd1, 16'h0004, 1'b0);
    do_wr(3'd1, 16'h0008, 1'b0);
    do_wr(3'd4, 16'd1, 1'b0);
    do_wr(3'd1, 16'h0002, 1'b0);
    ticks(9);   do_rd(3'd3); ticks(1);  do_rd(3'd3);
    ticks(9);   do_rd(3'd3); ticks(1);  do_rd(3'd2);
    ticks(79);  do_rd(3'd3); ticks(1);  do_rd(3'd3);
    ticks(899); do_rd(3'd2); do_rd(3'd3);
    ticks(1);   do_rd(3'd0);
    ticks(5);
    do_wr(3'd1, 16'h0002, 1'b0);
    do_rd(3'd0);
    ticks(3);
    do_rd(3'd2);
    do_rd(3'd3);
    do_wr(3'd1, 16'h0008, 1'b0);
    do_rd(3'd0);
    do_rd(3'd2);

    // collisions
    do_wr(3'd1, 16'h0002, 1'b0);
    ticks(3);
    do_wr(3'd1, 16'h000A, 1'b1);
    do_rd(3'd2);
    do_wr(3'd1, 16'h0006, 1'b0);
    do_rd(3'd0);
    do_wr(3'd1, 16'h0002, 1'b0);
    do_wr(3'd4, 16'd3, 1'b0);
    ticks(2);
    do_rd(3'd5);
    do_wr(3'd4, 16'd3, 1'b1);
    do_rd(3'd5);
    do_rd(3'd2);
    ticks(2);
    do_wr(3'd0, 16'h0000, 1'b1);
    do_rd(3'd0);

    // reset in the middle of counting, with a tick in the same cycle
    do_wr(3'd1, 16'h000B, 1'b0);
    ticks(113);
    do_rd(3'd2);
    do_rd(3'd5);
    drive(1'b1, 1'b0, 1'b1, 3'd0, 16'h0000, 1'b1);
    for (int i = 0; i < 6; i++) do_rd(3'(i));

    // random traffic
    do_wr(3'd4, 16'd2, 1'b0);
    do_wr(3'd1, 16'h0003, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      cs = 1'($urandom_range(0, 1));
      wn = ($urandom_range(0, 3) != 0);
      a  = 3'($urandom_range(0, 7));
      wd = 16'($urandom);
      tk = 1'($urandom_range(0, 1));
      if (!wn && a == 3'd4) wd = 16'($urandom_range(0, 5));
      if (!wn && a == 3'd1) begin
        wd[3] = ($urandom_range(0, 15) == 0);
        wd[2] = ($urandom_range(0, 7) == 0);
      end
      drive(1'b0, cs, wn, a, wd, tk);
    end

    repeat (3) drive(1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || exp_out_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d reads and %0d outputs still pending, expected 0 and 0",
               exp_q.size(), exp_out_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc1_game_clock.md
# soc1_game_clock

Elapsed-game-time counter for the Minesweeper SoC, placed directly downstream of the interval timer. It consumes the timer's one-cycle timeout strobe (1 ms at the 50 MHz default), prescales it to seconds, and keeps a saturating 0–999 s count in both binary and BCD. The BCD count drives the 7-segment display. Software reads, starts, stops and clears the count, and takes a per-second interrupt, through a 16-bit memory-mapped slave port.

## Interface
- `TICKS_PER_SEC`, default 1000: reset value of the prescale register.
- `MAX_SECONDS`, default 999: saturation value of the count.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `tick_in` in 1: one-cycle strobe from the timer timeout.
- `chipselect` in 1: slave select.
- `address` in 3: register index 0–5.
- `write_n` in 1: active-low write.
- `writedata` in 16: write data.
- `readdata` out 16: registered read data.
- `irq` out 1: per-second interrupt, level.
- `bcd_out` out 12: {hundreds, tens, units} BCD digits for the display.

## Operation
- Write strobe: `wr = chipselect & ~write_n`.
- Register map:
  - 0 STATUS, read: {saturated[2], sec_event[1], running[0]}. Any write clears bits 1 and 2.
  - 1 CONTROL: bit0 irq_en, stored and read back. Bit1 start, bit2 stop, bit3 clear are write-only strobes and read as 0.
  - 2 SECONDS: binary count, bits [9:0], read-only.
  - 3 BCD: {4'b0, bcd_out}, read-only.
  - 4 PRESCALE: R/W, 16 bits. A write also zeroes subtick. A value of 0 is treated as 1.
  - 5 SUBTICK: current sub-second count, read-only.
  - Reads of addresses 6–7 return 0. Writes to read-only registers are ignored.
- Counting happens only while running, on `tick_in`:
  - If subtick == PRESCALE−1: subtick←0, seconds and BCD increment, sec_event←1.
  - Otherwise: subtick increments.
- Saturation:
  - An increment that would exceed MAX_SECONDS is suppressed.
  - That tick sets saturated, clears running, and leaves seconds at MAX_SECONDS. sec_event is not set.
- BCD is three cascaded digit counters with carry. Units 9→0 increments tens; tens 9→0 increments hundreds. BCD must always equal SECONDS.
- Clear strobe: seconds, BCD and subtick ←0, saturated←0. running is unchanged.
- `irq = sec_event & irq_en`.
- Simultaneous-event priority:
  - clear beats a tick in the same cycle; the count ends at 0.
  - stop beats start in the same write.
  - Start while saturated is ignored; running stays 0 until a clear.
  - A sec_event set and a STATUS write in the same cycle leave sec_event = 1 (set wins).
  - A PRESCALE write and a tick in the same cycle leave subtick = 0 and do not advance seconds.

## Timing
- Reset values: `readdata`=0, `irq`=0, `bcd_out`=0, running=0, irq_en=0, seconds=0, subtick=0, PRESCALE=TICKS_PER_SEC.
- Read latency is one cycle. `readdata` is registered every cycle from the current `address`, regardless of `chipselect`.
- A tick sampled at edge N updates subtick, SECONDS and BCD at edge N. `irq` rises combinationally after that edge.
- A start written at edge N sets running at N. The first tick that counts is the one sampled at N+1.
- A stop written at edge N means a tick sampled at N is not counted.
- Reset overrides everything, including a `tick_in` in the same cycle.

## Structure
- Package `soc1_game_clock_pkg` holds:
  - address constants ADDR_STATUS … ADDR_SUBTICK;
  - STATUS and CONTROL bit-position constants;
  - the 4-bit BCD digit type.
- One sub-module, `soc1_bcd_counter3`: a three-digit BCD counter with inc, clr, and carry_out at 999. It is instantiated once.

## Test plan
- Reset, then read all 6 addresses → STATUS 0, CONTROL 0, SECONDS 0, BCD 0, PRESCALE 1000, SUBTICK 0.
- PRESCALE=4, irq_en=1, start, 8 ticks → SECONDS 2, BCD 0x002. `irq` high after tick 4; a STATUS write drops it; it rises again after tick 8.
- PRESCALE=1, run 999 ticks, then 1 more → SECONDS 999, BCD 0x999, running 0, saturated 1. Further ticks change nothing. Start is ignored until a clear.
- Count to 9, then 19, then 99 → BCD 0x009→0x010, 0x019→0x020, 0x099→0x100. BCD always matches SECONDS.
- Collisions:
  - clear and tick in the same cycle → SECONDS 0;
  - start|stop in one write → running 0;
  - PRESCALE write with tick → SUBTICK 0;
  - STATUS write coinciding with a second rollover → sec_event stays 1.
- Assert `reset` mid-count (SECONDS 37, SUBTICK 2) with `tick_in` high → all outputs 0 next cycle and PRESCALE back to default.
